// File: rtl/mult_arbiter_if.sv
// Bundle of requester, multiplier-core and response signals for mult_arbiter.
// The arbiter takes the slave view; its environment takes the master view.
interface mult_arbiter_if;
  logic       req0_valid;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       req1_ready;
  logic       mul_start;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic       mul_done;
  logic [7:0] mul_p;
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_p;
  logic       rsp_err;
  logic       rsp_ready;
  logic [7:0] jobs_done;
  logic [1:0] state_dbg;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  mul_start, mul_a, mul_b,
    output mul_done, mul_p,
    input  rsp_valid, rsp_id, rsp_p, rsp_err,
    output rsp_ready,
    input  jobs_done, state_dbg
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output mul_start, mul_a, mul_b,
    input  mul_done, mul_p,
    output rsp_valid, rsp_id, rsp_p, rsp_err,
    input  rsp_ready,
    output jobs_done, state_dbg
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier core between two requesters,
// with a watchdog on the core's done pulse and a tagged response port.
module mult_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic          sys_clk,
  input logic          sys_rst,
  mult_arbiter_if.slave bus
);
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // reqK_ready is combinational from state and valids; rsp_valid is held
  // with stable payload until rsp_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_grant;
  logic [7:0] timer;
  logic       grant;
  logic       any_valid;

  // On a tie the requester that did not win last time is favoured.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;

  assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant;
  assign bus.state_dbg  = state;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      timer         <= 8'd0;
      bus.mul_start <= 1'b0;
      bus.mul_a     <= 4'd0;
      bus.mul_b     <= 4'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_p     <= 8'd0;
      bus.rsp_err   <= 1'b0;
      bus.jobs_done <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            bus.mul_a     <= grant ? bus.req1_a : bus.req0_a;
            bus.mul_b     <= grant ? bus.req1_b : bus.req0_b;
            last_grant    <= grant;
            bus.mul_start <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mul_start <= 1'b0;
          timer         <= 8'd0;
          state         <= WAIT;
        end
        WAIT: begin
          // A done on the final watchdog cycle still counts as success.
          if (bus.mul_done) begin
            bus.rsp_p     <= bus.mul_p;
            bus.rsp_err   <= 1'b0;
            bus.rsp_id    <= last_grant;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (timer == TIMER_LAST) begin
            bus.rsp_p     <= 8'd0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_id    <= last_grant;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.jobs_done <= bus.jobs_done + 8'd1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed timing scenarios plus
// randomized traffic checked by a job-level round-robin reference model.
module tb_mult_arbiter;
  localparam int TO = 16;

  logic clk;
  logic rst;
  mult_arbiter_if bus ();

  mult_arbiter #(.TIMEOUT(TO)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // core model: done pulse core_delay cycles after mul_start; 0 = never
  logic core_done;
  logic spur_done;
  int   core_delay;
  int   cnt;
  assign bus.mul_done = core_done | spur_done;

  initial begin
    core_done  = 1'b0;
    bus.mul_p  = 8'd0;
    cnt        = 0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      bus.mul_p = 8'($urandom);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          bus.mul_p = {4'd0, bus.mul_a} * {4'd0, bus.mul_b};
        end
      end
      if (bus.mul_start && core_delay != 0) cnt = core_delay;
    end
  end

  // reference model: jobs, round-robin rule, expected responses
  logic [9:0] exp_q[$];
  bit         m_busy;
  bit         m_last;
  int         m_jobs;

  initial begin
    bit         e0, e1, g, err;
    logic [3:0] a, b;
    logic [7:0] p;
    m_busy = 1'b0;
    m_last = 1'b1;
    m_jobs = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 1'b0;
        m_last = 1'b1;
        m_jobs = 0;
        exp_q.delete();
      end else begin
        e0 = 1'b0;
        e1 = 1'b0;
        g  = 1'b0;
        if (!m_busy && (bus.req0_valid || bus.req1_valid)) begin
          g  = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
          e0 = !g;
          e1 = g;
        end
        total++;
        if (bus.req0_ready !== e0 || bus.req1_ready !== e1) begin
          bad++;
          $display("FAIL ready: got req0_ready=%b req1_ready=%b, required %b %b at %0t",
                   bus.req0_ready, bus.req1_ready, e0, e1, $time);
        end
        total++;
        if (bus.jobs_done !== 8'(m_jobs)) begin
          bad++;
          $display("FAIL jobs_done: got %0d, required %0d at %0t", bus.jobs_done, 8'(m_jobs), $time);
        end
        if (e0 || e1) begin
          a   = g ? bus.req1_a : bus.req0_a;
          b   = g ? bus.req1_b : bus.req0_b;
          err = (core_delay == 0) || (core_delay > TO);
          p   = err ? 8'd0 : ({4'd0, a} * {4'd0, b});
          exp_q.push_back({g, err, p});
          m_last = g;
          m_busy = 1'b1;
        end
        if (bus.rsp_valid) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: got id=%b err=%b p=%0d, required no response at %0t",
                     bus.rsp_id, bus.rsp_err, bus.rsp_p, $time);
          end else if ({bus.rsp_id, bus.rsp_err, bus.rsp_p} !== exp_q[0]) begin
            bad++;
            $display("FAIL rsp: got id=%b err=%b p=%0d, required id=%b err=%b p=%0d at %0t",
                     bus.rsp_id, bus.rsp_err, bus.rsp_p, exp_q[0][9], exp_q[0][8], exp_q[0][7:0], $time);
          end
          if (bus.rsp_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            m_busy = 1'b0;
            m_jobs++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && m_busy; i++) tick();
    total++;
    if (m_busy) begin
      bad++;
      $display("FAIL %s_drain: job still pending after 80 cycles, required completion", name);
    end
  endtask

  task automatic run_one(input bit k, input int d, input string name);
    bit got;
    core_delay    = d;
    bus.rsp_ready = 1'b1;
    if (k) begin
      bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom); bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom); bus.req0_valid = 1'b1;
    end
    #1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if ((k ? bus.req1_ready : bus.req0_ready) === 1'b1) got = 1'b1;
      else tick();
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_accept: ready never rose, required accept", name);
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready = 0;
    spur_done = 0;
    core_delay = 2;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({bus.mul_start, bus.mul_a, bus.mul_b, bus.rsp_valid, bus.rsp_id, bus.rsp_p,
         bus.rsp_err, bus.jobs_done, bus.req0_ready, bus.req1_ready} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs: got start=%b a=%0d b=%0d rv=%b id=%b p=%0d err=%b jd=%0d r0=%b r1=%b, required all 0",
               bus.mul_start, bus.mul_a, bus.mul_b, bus.rsp_valid, bus.rsp_id, bus.rsp_p,
               bus.rsp_err, bus.jobs_done, bus.req0_ready, bus.req1_ready);
    end
  endtask

  task automatic test_alternate();
    bit seq[4];
    int n;
    core_delay = 1;
    bus.rsp_ready = 1'b1;
    bus.req0_a = 4'd15; bus.req0_b = 4'd15;
    bus.req1_a = 4'd2;  bus.req1_b = 4'd7;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (bus.req0_ready === 1'b1) begin seq[n] = 1'b0; n++; end
      else if (bus.req1_ready === 1'b1) begin seq[n] = 1'b1; n++; end
      if (n < 4) tick();
    end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    total++;
    if (n != 4 || {seq[0], seq[1], seq[2], seq[3]} !== 4'b0101) begin
      bad++;
      $display("FAIL alternate_order: got %0d grants %b%b%b%b, required 4 grants 0101",
               n, seq[0], seq[1], seq[2], seq[3]);
    end
    drain("alternate");
    tick();
    total++;
    if (bus.jobs_done !== 8'd4) begin
      bad++;
      $display("FAIL alternate_jobs: got %0d, required 4", bus.jobs_done);
    end
  endtask

  task automatic test_single();
    core_delay = 2;
    bus.rsp_ready = 1'b0;
    bus.req0_a = 4'd3; bus.req0_b = 4'd5; bus.req0_valid = 1'b1;
    #1;
    total++;
    if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b, required 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0;
    total++;
    if (bus.mul_start !== 1'b1) begin bad++; $display("FAIL single_start: got %b, required 1 at T+1", bus.mul_start); end
    tick();
    total++;
    if (bus.mul_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_t2: got start=%b rv=%b, required 0 0", bus.mul_start, bus.rsp_valid);
    end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_t3: got rv=%b, required 0", bus.rsp_valid); end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_p !== 8'd15 || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp: got rv=%b id=%b p=%0d err=%b, required 1 0 15 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.rsp_err);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    total++;
    if (bus.jobs_done !== 8'd5 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_done: got jd=%0d rv=%b, required 5 0", bus.jobs_done, bus.rsp_valid);
    end
  endtask

  task automatic test_timeout();
    core_delay = 0;
    bus.rsp_ready = 1'b0;
    bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom); bus.req1_valid = 1'b1;
    #1;
    total++;
    if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL timeout_ready: got %b, required 1", bus.req1_ready); end
    tick();
    bus.req1_valid = 1'b0;
    repeat (16) tick();
    total++;
    if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL timeout_early: got rv=%b at T+17, required 0", bus.rsp_valid); end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_p !== 8'd0 || bus.rsp_id !== 1'b1) begin
      bad++;
      $display("FAIL timeout_rsp: got rv=%b err=%b p=%0d id=%b at T+18, required 1 1 0 1",
               bus.rsp_valid, bus.rsp_err, bus.rsp_p, bus.rsp_id);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    run_one(1'b0, TO, "done_on_last");
    run_one(1'b1, TO + 1, "done_too_late");
    run_one(1'b0, 2, "after_timeout");
  endtask

  task automatic test_backpressure();
    logic [7:0] p0;
    bit         seen;
    core_delay = 2;
    bus.rsp_ready = 1'b0;
    bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom); bus.req0_valid = 1'b1;
    p0 = {4'd0, bus.req0_a} * {4'd0, bus.req0_b};
    tick();
    bus.req0_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom); bus.req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.req1_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_p !== p0 || bus.rsp_id !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d: got r1=%b rv=%b p=%0d id=%b, required 0 1 %0d 0",
                 i, bus.req1_ready, bus.rsp_valid, bus.rsp_p, bus.rsp_id, p0);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    total++;
    if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL release_same: got r1=%b, required 0", bus.req1_ready); end
    tick();
    total++;
    if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL release_next: got r1=%b, required 1", bus.req1_ready); end
    tick();
    bus.req1_valid = 1'b0;
    drain("backpressure");
  endtask

  task automatic test_spurious();
    logic [7:0] p0;
    bus.rsp_ready = 1'b0;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (2) begin
      tick();
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.mul_start !== 1'b0) begin
        bad++; $display("FAIL spur_idle: got rv=%b start=%b, required 0 0", bus.rsp_valid, bus.mul_start);
      end
    end
    core_delay = 3;
    bus.req0_a = 4'($urandom_range(1, 15)); bus.req0_b = 4'($urandom_range(1, 15)); bus.req0_valid = 1'b1;
    p0 = {4'd0, bus.req0_a} * {4'd0, bus.req0_b};
    tick();
    bus.req0_valid = 1'b0;
    spur_done = 1'b1;
    total++;
    if (bus.mul_start !== 1'b1) begin bad++; $display("FAIL spur_start: got %b, required 1", bus.mul_start); end
    tick();
    spur_done = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      total++;
      if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL spur_t%0d: got rv=%b, required 0", i, bus.rsp_valid); end
      tick();
    end
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== p0 || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL spur_rsp: got rv=%b p=%0d err=%b, required 1 %0d 0", bus.rsp_valid, bus.rsp_p, bus.rsp_err, p0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    core_delay = 4;
    bus.rsp_ready = 1'b1;
    bus.req0_a = 4'($urandom_range(1, 15)); bus.req0_b = 4'($urandom_range(1, 15)); bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      total++;
      if ({bus.mul_start, bus.mul_a, bus.mul_b, bus.rsp_valid, bus.rsp_id, bus.rsp_p,
           bus.rsp_err, bus.jobs_done} !== 28'd0) begin
        bad++;
        $display("FAIL midrst_t%0d: got start=%b a=%0d b=%0d rv=%b id=%b p=%0d err=%b jd=%0d, required all 0",
                 i, bus.mul_start, bus.mul_a, bus.mul_b, bus.rsp_valid, bus.rsp_id, bus.rsp_p,
                 bus.rsp_err, bus.jobs_done);
      end
      tick();
    end
    bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom);
    bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    total++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_tie: got r0=%b r1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain("midrst");
  endtask

  task automatic test_random();
    int delays[4] = '{1, 3, 0, 2};
    for (int ch = 0; ch < 4; ch++) begin
      core_delay = delays[ch];
      for (int c = 0; c < 150; c++) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom);
        bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom);
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      drain("random");
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_timeout();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    test_random();
    repeat (2) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
